// File: rtl/loop_fetch_stage.sv
// Fetch stage feeding the IF/ID register: owns the PC, picks each word from instruction
// memory or the loop-buffer replay output, and recovers from loop-buffer flushes.
module loop_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          LB_DEPTH  = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic [31:0] loop_target,
  input  logic        lb_block,
  input  logic        lb_flush,
  input  logic [31:0] lb_new_pc,
  input  logic [31:0] lb_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        fetch_src,
  output logic        loop_reject,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_LOOP     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam logic [31:0] LB_DEPTH_W = 32'(LB_DEPTH);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        fetch_src_q, fetch_src_d;
  logic        loop_reject_q, loop_reject_d;
  logic [31:0] loop_start_q, loop_start_d;
  logic [31:0] loop_end_q, loop_end_d;
  logic        lb_block_prev_q, lb_block_prev_d;
  logic [31:0] loop_len;

  // Body length of a candidate loop ending at the word currently in IF/ID.
  assign loop_len = ((ifid_pc_q - loop_target) >> 2) + 32'd1;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_src_d     = fetch_src_q;
    loop_reject_d   = 1'b0;
    loop_start_d    = loop_start_q;
    loop_end_d      = loop_end_q;
    lb_block_prev_d = lb_block_prev_q;

    if (lb_flush) begin
      ifid_valid_d    = 1'b0;
      ifid_instr_d    = NOP_INSTR;
      fetch_src_d     = 1'b0;
      lb_block_prev_d = lb_block;
      state_d         = ST_REDIRECT;
    end else if (state_q == ST_REDIRECT) begin
      // Recovery PC arrives one cycle after the flush; stall cannot hold this cycle.
      pc_d            = lb_new_pc;
      ifid_valid_d    = 1'b0;
      ifid_instr_d    = NOP_INSTR;
      fetch_src_d     = 1'b0;
      lb_block_prev_d = lb_block;
      state_d         = ST_FETCH;
    end else if (!stall) begin
      lb_block_prev_d = lb_block;
      case (state_q)
        ST_FETCH: begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem_rdata;
          ifid_valid_d = 1'b1;
          fetch_src_d  = 1'b0;
          pc_d         = pc_q + 32'd4;
          if (lb_block && !lb_block_prev_q) begin
            loop_start_d = loop_target;
            loop_end_d   = ifid_pc_q;
            if (loop_len <= LB_DEPTH_W) begin
              pc_d         = loop_target;
              ifid_pc_d    = ifid_pc_q;
              ifid_valid_d = 1'b0;
              ifid_instr_d = NOP_INSTR;
              state_d      = ST_LOOP;
            end else begin
              loop_reject_d = 1'b1;
            end
          end
        end
        ST_LOOP: begin
          if (!lb_block) begin
            pc_d         = loop_end_q + 32'd4;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            fetch_src_d  = 1'b0;
            state_d      = ST_FETCH;
          end else begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = lb_instr;
            ifid_valid_d = 1'b1;
            fetch_src_d  = 1'b1;
            pc_d         = (pc_q == loop_end_q) ? loop_start_q : pc_q + 32'd4;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_FETCH;
      pc_q            <= RESET_PC;
      ifid_pc_q       <= 32'd0;
      ifid_instr_q    <= NOP_INSTR;
      ifid_valid_q    <= 1'b0;
      fetch_src_q     <= 1'b0;
      loop_reject_q   <= 1'b0;
      loop_start_q    <= 32'd0;
      loop_end_q      <= 32'd0;
      lb_block_prev_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_valid_q    <= ifid_valid_d;
      fetch_src_q     <= fetch_src_d;
      loop_reject_q   <= loop_reject_d;
      loop_start_q    <= loop_start_d;
      loop_end_q      <= loop_end_d;
      lb_block_prev_q <= lb_block_prev_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_src   = fetch_src_q;
  assign loop_reject = loop_reject_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_loop_fetch_stage.sv
// Bench for loop_fetch_stage: directed fetch/loop/flush/reset sequences with a scoreboard
// of expected IF/ID words, plus a second instance exercising PC wrap-around.
module tb_loop_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] loop_target = 32'd0;
  logic        lb_block = 1'b0;
  logic        lb_flush = 1'b0;
  logic [31:0] lb_new_pc = 32'd0;
  logic [31:0] lb_instr;
  logic [31:0] ifid_pc, ifid_instr;
  logic        ifid_valid, fetch_src, loop_reject;
  logic [1:0]  dbg_state;

  logic        reset2 = 1'b1;
  logic [31:0] d2_imem_addr, d2_imem_rdata, d2_ifid_pc, d2_ifid_instr;
  logic        d2_ifid_valid, d2_fetch_src, d2_loop_reject;
  logic [1:0]  d2_dbg_state;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0]  S_FETCH = 2'd0, S_LOOP = 2'd1, S_REDIRECT = 2'd2;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];
  logic [64:0] exp2_q[$];
  logic [64:0] mon_e, mon2_e;
  logic        upd1 = 1'b0, upd2 = 1'b0;

  always #5 clk = ~clk;

  assign imem_rdata    = imem_addr ^ 32'h0000_A5A5;
  assign lb_instr      = imem_addr ^ 32'h5A5A_0000;
  assign d2_imem_rdata = d2_imem_addr ^ 32'h0000_A5A5;

  loop_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .loop_target(loop_target), .lb_block(lb_block), .lb_flush(lb_flush), .lb_new_pc(lb_new_pc),
    .lb_instr(lb_instr), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .fetch_src(fetch_src), .loop_reject(loop_reject), .dbg_state(dbg_state)
  );

  loop_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset2), .stall(1'b0), .imem_addr(d2_imem_addr), .imem_rdata(d2_imem_rdata),
    .loop_target(32'd0), .lb_block(1'b0), .lb_flush(1'b0), .lb_new_pc(32'd0),
    .lb_instr(32'd0), .ifid_pc(d2_ifid_pc), .ifid_instr(d2_ifid_instr), .ifid_valid(d2_ifid_valid),
    .fetch_src(d2_fetch_src), .loop_reject(d2_loop_reject), .dbg_state(d2_dbg_state)
  );

  // An edge produces a new IF/ID word unless reset or a plain stall held it.
  always @(posedge clk) begin
    upd1 <= !reset && (!stall || lb_flush);
    upd2 <= !reset2;
  end

  always @(negedge clk) begin
    if (upd1 && ifid_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ifid_unexpected: got pc %h instr %h src %b, expected no valid word",
                 ifid_pc, ifid_instr, fetch_src);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ifid_pc, ifid_instr, fetch_src} !== mon_e) begin
          errors++;
          $display("FAIL ifid_word: got pc %h instr %h src %b, expected pc %h instr %h src %b",
                   ifid_pc, ifid_instr, fetch_src, mon_e[64:33], mon_e[32:1], mon_e[0]);
        end
      end
    end
    if (upd2 && d2_ifid_valid) begin
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL wrap_unexpected: got pc %h, expected no valid word", d2_ifid_pc);
      end else begin
        mon2_e = exp2_q.pop_front();
        if ({d2_ifid_pc, d2_ifid_instr, d2_fetch_src} !== mon2_e) begin
          errors++;
          $display("FAIL wrap_word: got pc %h instr %h, expected pc %h instr %h",
                   d2_ifid_pc, d2_ifid_instr, mon2_e[64:33], mon2_e[32:1]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_imem(input logic [31:0] a);
    exp_q.push_back({a, a ^ 32'h0000_A5A5, 1'b0});
  endtask

  task automatic push_lb(input logic [31:0] a);
    exp_q.push_back({a, a ^ 32'h5A5A_0000, 1'b1});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(ifid_valid), 32'd0);
    check({tag, "_instr"}, ifid_instr, NOP);
    check({tag, "_pc"}, ifid_pc, 32'd0);
    check({tag, "_src"}, 32'(fetch_src), 32'd0);
    check({tag, "_reject"}, 32'(loop_reject), 32'd0);
    check({tag, "_imem_addr"}, imem_addr, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_FETCH));
  endtask

  initial begin
    tick();
    tick();
    check_reset_outputs("reset");
    check("wrap_reset_addr", d2_imem_addr, 32'hFFFF_FFF8);
    check("wrap_reset_valid", 32'(d2_ifid_valid), 32'd0);

    // Wrap-around: second instance fetches across 2^32.
    reset2 = 1'b0;
    exp2_q.push_back({32'hFFFF_FFF8, 32'hFFFF_5A5D, 1'b0}); tick();
    exp2_q.push_back({32'hFFFF_FFFC, 32'hFFFF_5A59, 1'b0}); tick();
    exp2_q.push_back({32'h0000_0000, 32'h0000_A5A5, 1'b0}); tick();
    reset2 = 1'b1;

    // Straight-line fetch up to ifid_pc = 0x40.
    reset = 1'b0;
    for (int a = 0; a <= 'h40; a += 4) begin
      push_imem(32'(a));
      tick();
    end
    check("fetch_pc_40", ifid_pc, 32'h40);

    // Loop entry 0x30..0x40 (5 words).
    loop_target = 32'h30; lb_block = 1'b1;
    tick();
    check("entry_bubble", 32'(ifid_valid), 32'd0);
    check("entry_state", 32'(dbg_state), 32'(S_LOOP));
    check("entry_pc", imem_addr, 32'h30);
    push_lb(32'h30); tick();
    push_lb(32'h34); tick();
    push_lb(32'h38); tick();
    push_lb(32'h3C); tick();
    push_lb(32'h40); tick();
    push_lb(32'h30); tick();
    push_lb(32'h34); tick();

    // Flush under stall, then redirect to 0x44 (stall during REDIRECT ignored).
    lb_flush = 1'b1; stall = 1'b1;
    tick();
    check("flush_bubble", 32'(ifid_valid), 32'd0);
    check("flush_instr", ifid_instr, NOP);
    check("flush_state", 32'(dbg_state), 32'(S_REDIRECT));
    check("flush_pc_hold", imem_addr, 32'h38);
    lb_flush = 1'b0; lb_block = 1'b0; lb_new_pc = 32'h44;
    tick();
    check("redirect_bubble", 32'(ifid_valid), 32'd0);
    check("redirect_state", 32'(dbg_state), 32'(S_FETCH));
    check("redirect_pc", imem_addr, 32'h44);
    stall = 1'b0;
    push_imem(32'h44); tick();
    push_imem(32'h48); tick();

    // Oversize loop (len 19) is refused; reject is a single-cycle pulse.
    loop_target = 32'h00; lb_block = 1'b1;
    push_imem(32'h4C); tick();
    check("reject_pulse", 32'(loop_reject), 32'd1);
    check("reject_state", 32'(dbg_state), 32'(S_FETCH));
    push_imem(32'h50); tick();
    check("reject_clear", 32'(loop_reject), 32'd0);
    lb_block = 1'b0;
    push_imem(32'h54); tick();

    // Boundary: len 9 refused, len 8 accepted.
    loop_target = 32'h34; lb_block = 1'b1;
    push_imem(32'h58); tick();
    check("len9_reject", 32'(loop_reject), 32'd1);
    lb_block = 1'b0;
    push_imem(32'h5C); tick();
    loop_target = 32'h40; lb_block = 1'b1;
    tick();
    check("len8_reject", 32'(loop_reject), 32'd0);
    check("len8_state", 32'(dbg_state), 32'(S_LOOP));
    for (int a = 'h40; a <= 'h5C; a += 4) begin
      push_lb(32'(a));
      tick();
    end
    push_lb(32'h40); tick();

    // Loop exit resumes at loop_end + 4.
    lb_block = 1'b0;
    tick();
    check("exit_bubble", 32'(ifid_valid), 32'd0);
    check("exit_state", 32'(dbg_state), 32'(S_FETCH));
    check("exit_pc", imem_addr, 32'h60);
    push_imem(32'h60); tick();

    // Stall holds everything and defers the lb_block edge.
    stall = 1'b1; lb_block = 1'b1; loop_target = 32'h00;
    tick();
    check("stall_ifid_pc", ifid_pc, 32'h60);
    check("stall_addr", imem_addr, 32'h64);
    check("stall_no_reject", 32'(loop_reject), 32'd0);
    stall = 1'b0;
    push_imem(32'h64); tick();
    check("deferred_reject", 32'(loop_reject), 32'd1);
    lb_block = 1'b0;
    push_imem(32'h68); tick();

    // Reset taken mid-loop.
    loop_target = 32'h60; lb_block = 1'b1;
    tick();
    push_lb(32'h60); tick();
    push_lb(32'h64); tick();
    reset = 1'b1; lb_block = 1'b0;
    tick();
    check_reset_outputs("loop_reset");
    reset = 1'b0;
    push_imem(32'h0); tick();

    // Back-to-back flushes extend REDIRECT by one cycle.
    lb_flush = 1'b1;
    tick();
    check("flush1_state", 32'(dbg_state), 32'(S_REDIRECT));
    tick();
    check("flush2_state", 32'(dbg_state), 32'(S_REDIRECT));
    check("flush2_pc_hold", imem_addr, 32'h4);
    lb_flush = 1'b0; lb_new_pc = 32'h100;
    tick();
    check("redirect2_pc", imem_addr, 32'h100);
    push_imem(32'h100); tick();
    push_imem(32'h104); tick();
    tick();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp2_q_drained", 32'(exp2_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
